// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder for the DLX memory_access stage
// Accepts one load/store at a time, stalls for WAIT_STATES cycles, then acks with aligned load data.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_in,
  input  logic                  mem_wr_en_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_signed_in,
  input  logic [ADDR_WIDTH+1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_stall_out,
  output logic                  mem_ack_out,
  output logic                  mem_err_out,
  output logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];

  logic                    cur_we;
  logic [1:0]              cur_size;
  logic                    cur_signed;
  logic [ADDR_WIDTH+1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic                    misaligned;
  logic                    access;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rword;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_val;

  // In IDLE the access uses the live request (zero-wait path); afterwards only latched values.
  always_comb begin
    cur_we     = mem_wr_en_in;
    cur_size   = mem_size_in;
    cur_signed = mem_signed_in;
    cur_addr   = mem_addr_in;
    cur_data   = mem_data_in;
    if (state != IDLE) begin
      cur_we     = we_q;
      cur_size   = size_q;
      cur_signed = signed_q;
      cur_addr   = addr_q;
      cur_data   = data_q;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (mem_size_in)
      2'b01:   misaligned = mem_addr_in[0];
      2'b10:   misaligned = |mem_addr_in[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  assign access = ((state == IDLE) && mem_req_in && !misaligned && (WAIT_STATES == 0))
                || ((state == WAIT) && (cnt == 4'd0));

  assign mem_stall_out = ((state == IDLE) && mem_req_in) || (state == WAIT);

  always_comb begin
    be    = 4'b1111;
    wdata = cur_data;
    case (cur_size)
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wdata = {4{cur_data[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = cur_data;
      end
    endcase
  end

  assign rword = mem[cur_addr[ADDR_WIDTH+1:2]];

  always_comb begin
    shifted  = rword >> {cur_addr[1:0], 3'b000};
    load_val = rword;
    case (cur_size)
      2'b00:   load_val = {{(DATA_WIDTH-8){cur_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{(DATA_WIDTH-16){cur_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  // RAM is not reset; a reset asserted at the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (access && cur_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mem_ack_out  <= 1'b0;
      mem_err_out  <= 1'b0;
      mem_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack_out  <= 1'b0;
          mem_err_out  <= 1'b0;
          mem_data_out <= '0;
          if (mem_req_in) begin
            we_q     <= mem_wr_en_in;
            size_q   <= mem_size_in;
            signed_q <= mem_signed_in;
            addr_q   <= mem_addr_in;
            data_q   <= mem_data_in;
            if (misaligned) begin
              state       <= RESP;
              mem_ack_out <= 1'b1;
              mem_err_out <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state        <= RESP;
              mem_ack_out  <= 1'b1;
              mem_data_out <= mem_wr_en_in ? '0 : load_val;
            end else begin
              state <= WAIT;
              cnt   <= WS_M1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            mem_ack_out  <= 1'b1;
            mem_data_out <= we_q ? '0 : load_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          mem_ack_out  <= 1'b0;
          mem_err_out  <= 1'b0;
          mem_data_out <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
// Byte-array reference model; instances with WAIT_STATES=2 and WAIT_STATES=0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req0, we, sgn;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        stall, ack, err, stall0, ack0, err0;
  logic [31:0] dout, dout0;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:4095];

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .mem_req_in(req), .mem_wr_en_in(we), .mem_size_in(size),
    .mem_signed_in(sgn), .mem_addr_in(addr), .mem_data_in(wdata),
    .mem_stall_out(stall), .mem_ack_out(ack), .mem_err_out(err), .mem_data_out(dout)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req_in(req0), .mem_wr_en_in(we), .mem_size_in(size),
    .mem_signed_in(sgn), .mem_addr_in(addr), .mem_data_in(wdata),
    .mem_stall_out(stall0), .mem_ack_out(ack0), .mem_err_out(err0), .mem_data_out(dout0)
  );

  always #5 clk = ~clk;

  function automatic bit is_mis(input logic [1:0] s, input logic [11:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [11:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) model[a + 12'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [11:0] a);
    logic [31:0] v = 32'd0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = model[a + 12'(i)];
    if (sg && n < 4 && v[8*n-1]) for (int i = n * 8; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Issues one request to the WAIT_STATES=2 instance and records what comes back.
  task automatic issue(input logic w, input logic [1:0] s, input logic sg, input logic [11:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e, output int nstall, output logic ack_after);
    @(negedge clk);
    req = 1'b1; we = w; size = s; sgn = sg; addr = a; wdata = d;
    lat = -1; nstall = 0; rd = 32'd0; e = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      if (ack) begin
        lat = k; rd = dout; e = err;
        if (stall) nstall = nstall + 100;
        break;
      end
      if (stall) nstall++;
      @(negedge clk);
      req = 1'b0;
    end
    req = 1'b0;
    @(negedge clk);
    #1 ack_after = ack;
  endtask

  // Runs one request and compares every response field against the model.
  task automatic run_and_check(input string name, input logic w, input logic [1:0] s,
                               input logic sg, input logic [11:0] a, input logic [31:0] d);
    int lat, nst;
    logic [31:0] rd, exp_d;
    logic e, aa;
    bit mis = is_mis(s, a);
    exp_d = (mis || w) ? 32'd0 : model_load(s, sg, a);
    issue(w, s, sg, a, d, lat, rd, e, nst, aa);
    if (!mis && w) model_store(s, a, d);
    checks += 4;
    if (lat !== (mis ? 1 : 3)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, mis ? 1 : 3); end
    if (nst !== (mis ? 1 : 3)) begin errors++; $display("FAIL %s stall cycles: got %0d expected %0d", name, nst, mis ? 1 : 3); end
    if (e !== mis) begin errors++; $display("FAIL %s err: got %b expected %b", name, e, mis); end
    if (rd !== exp_d) begin errors++; $display("FAIL %s data: got %h expected %h", name, rd, exp_d); end
    checks++;
    if (aa !== 1'b0) begin errors++; $display("FAIL %s ack after RESP: got %b expected 0", name, aa); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks += 2;
    if ({ack, err, stall, dout} !== 35'd0) begin errors++; $display("FAIL reset ws2 outputs: got %h expected 0", {ack, err, stall, dout}); end
    if ({ack0, err0, stall0, dout0} !== 35'd0) begin errors++; $display("FAIL reset ws0 outputs: got %h expected 0", {ack0, err0, stall0, dout0}); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    run_and_check("word_store", 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    run_and_check("word_load", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    checks++;
    if (model_load(2'd2, 1'b0, 12'h010) !== 32'hDEADBEEF) begin errors++; $display("FAIL word model: got %h expected deadbeef", model_load(2'd2, 1'b0, 12'h010)); end
  endtask

  task automatic test_byte_lanes;
    run_and_check("byte_prefill", 1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344);
    run_and_check("byte_store", 1'b1, 2'd0, 1'b0, 12'h023, 32'hFFFFFF80);
    run_and_check("byte_signed", 1'b0, 2'd0, 1'b1, 12'h023, 32'h0);
    run_and_check("byte_unsigned", 1'b0, 2'd0, 1'b0, 12'h023, 32'h0);
    run_and_check("byte_word", 1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
  endtask

  task automatic test_halfword;
    run_and_check("half_prefill", 1'b1, 2'd2, 1'b0, 12'h040, 32'hAABBCCDD);
    run_and_check("half_store", 1'b1, 2'd1, 1'b0, 12'h042, 32'h00001234);
    run_and_check("half_word", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
    run_and_check("half_signed_lo", 1'b0, 2'd1, 1'b1, 12'h040, 32'h0);
  endtask

  task automatic test_misaligned;
    run_and_check("mis_half", 1'b1, 2'd1, 1'b0, 12'h041, 32'h0000FFFF);
    run_and_check("mis_word", 1'b1, 2'd2, 1'b0, 12'h042, 32'h55555555);
    run_and_check("mis_size3", 1'b0, 2'd3, 1'b0, 12'h040, 32'h0);
    run_and_check("mis_after", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
  endtask

  task automatic test_reset_in_wait;
    int seen = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 12'h040; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack, err, stall, dout} !== 35'd0) begin errors++; $display("FAIL rst_wait outputs: got %h expected 0", {ack, err, stall, dout}); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 if (ack) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_wait ack: got %0d acks expected 0", seen); end
    run_and_check("rst_wait_retained", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) run_and_check("rand_fill", 1'b1, 2'd2, 1'b0, 12'(4 * i), $urandom);
    for (int i = 0; i < 40; i++)
      run_and_check("rand_op", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; size = 2'd2; sgn = 1'b0; addr = 12'h100; wdata = 32'h5A5AA5A5;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks += 2;
      if (ack0 !== 1'(k % 2)) begin errors++; $display("FAIL b2b ack cycle %0d: got %b expected %b", k, ack0, 1'(k % 2)); end
      if (stall0 !== 1'((k + 1) % 2)) begin errors++; $display("FAIL b2b stall cycle %0d: got %b expected %b", k, stall0, 1'((k + 1) % 2)); end
      @(negedge clk);
    end
    we = 1'b0;
    #1;
    checks++;
    if (stall0 !== 1'b1) begin errors++; $display("FAIL b2b load stall: got %b expected 1", stall0); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checks++;
    if ({ack0, err0, dout0} !== {2'b10, 32'h5A5AA5A5}) begin
      errors++; $display("FAIL b2b load: got %b%b %h expected 10 5a5aa5a5", ack0, err0, dout0);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte_lanes;
    test_halfword;
    test_misaligned;
    test_reset_in_wait;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder serving the memory_access stage of the DLX pipeline.
- Accepts one load or store request at a time from the stage.
- Stalls the pipeline for a parameterised number of wait states.
- Performs a byte, halfword or word access on an internal synchronous RAM, then returns aligned and extended load data with a one-cycle acknowledge.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for the lane logic.
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 2, extra cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_req_in  in  1  access request from memory_access.
- mem_wr_en_in  in  1  1 = store, 0 = load.
- mem_size_in  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- mem_signed_in  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- mem_addr_in  in  ADDR_WIDTH+2  byte address.
- mem_data_in  in  DATA_WIDTH  store data, right-aligned.
- mem_stall_out  out  1  freeze the pipeline while high.
- mem_ack_out  out  1  one-cycle completion pulse.
- mem_err_out  out  1  one-cycle misalignment/reserved-size flag, coincident with ack.
- mem_data_out  out  DATA_WIDTH  load result, valid while ack=1.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Wait counter is 4 bits wide.
- Reset:
  - state=IDLE, counter=0, mem_ack_out=0, mem_err_out=0, mem_data_out=0.
  - mem_stall_out=0 (combinational, follows from IDLE with req low).
  - RAM contents are not reset.
- Misaligned request, checked in IDLE:
  - halfword with addr[0]=1, word with addr[1:0]!=0, or size=11.
- Acceptance (cycle T, IDLE, req=1):
  - Latch we, size, signed, addr, data.
  - Aligned request: go to WAIT if WAIT_STATES>0, else go to RESP.
  - Misaligned request: go straight to RESP with the error flag set.
- WAIT:
  - Counter loads WAIT_STATES-1 at acceptance and decrements each cycle.
  - At count 0 go to RESP.
  - Req and the inputs are ignored in WAIT; only the latched values are used.
- RAM access happens on the clock edge that enters RESP:
  - Store: write byte lanes only. Byte uses lane addr[1:0], little-endian (lane k = bits 8k+7:8k). Halfword uses lanes addr[1]*2 and addr[1]*2+1. Word uses all lanes.
  - Load: read the word, select the lane(s), sign- or zero-extend to 32 bits, and register the result into mem_data_out.
  - Store: mem_data_out=0.
  - Misaligned: no RAM write; mem_data_out=0, mem_err_out=1.
- RESP:
  - mem_ack_out=1 for exactly one cycle, then unconditional return to IDLE.
  - A req seen in RESP is ignored; the pipeline advances at that edge and presents its next request in the following IDLE cycle.
- mem_stall_out is combinational:
  - = (IDLE & req) | WAIT.
  - High from cycle T through T+WAIT_STATES (misaligned: T only).
  - Low in RESP.
- Latency:
  - Aligned: ack at T+WAIT_STATES+1.
  - Misaligned: ack at T+1.
- Idle request gap: back-to-back requests give one IDLE cycle between RESP and the next acceptance.
- ack, err and data_out fall to 0 when leaving RESP.
- Reset mid-operation (in WAIT): abort, no RAM write, no ack, state=IDLE.
- Address bits above ADDR_WIDTH+1 do not exist; all RAM addresses are in range.

Test Plan:
- Word store then load, WAIT_STATES=2:
  - Store addr 0x010, data 0xDEADBEEF → stall high for 3 cycles, ack at T+3.
  - Load addr 0x010 → mem_data_out=0xDEADBEEF with ack.
- Byte lanes and extension:
  - Store byte 0x80 to addr 0x023.
  - Signed byte load of 0x023 → 0xFFFFFF80.
  - Unsigned byte load of 0x023 → 0x00000080.
  - Word load of 0x020 → 0x80xxxxxx, with the other lanes unchanged.
- Halfword: store 0x1234 at addr 0x042, then word load of 0x040 → upper half = 0x1234.
- Misaligned requests:
  - Halfword at 0x041 → ack and err at T+1, data_out=0, stall high only at T.
  - Subsequent word load of 0x040 shows memory unchanged.
- Reset in WAIT: store in flight, rst pulsed in the WAIT cycle → no ack, location retains its old value, all outputs 0.
- WAIT_STATES=0 with back-to-back requests held high: ack every second cycle, stall high exactly in each acceptance cycle.
